// File: rtl/stream_record_pkg.sv
// Stream record layout shared by the Ax snooper and its replay counterpart:
// field offsets, record type codes and the decoded Ax command record.
package stream_record_pkg;

  localparam logic [2:0] REC_AR = 3'd0;
  localparam logic [2:0] REC_AW = 3'd1;
  localparam logic [2:0] REC_R  = 3'd2;
  localparam logic [2:0] REC_W  = 3'd3;
  localparam logic [2:0] REC_B  = 3'd4;

  localparam int DEF_ID_W   = 32;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_ADDR_W = 64;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_LEN_W-1:0]  len;
    logic [DEF_ADDR_W-1:0] addr;
  } ax_cmd_t;

  // Fields are packed from the MSB down: type, id, len; addr sits at bit 0.
  function automatic int type_lsb(input int dw, input int stw);
    return dw - stw;
  endfunction

  function automatic int id_lsb(input int dw, input int stw, input int idw);
    return dw - stw - idw;
  endfunction

  function automatic int len_lsb(input int dw, input int stw, input int idw, input int lw);
    return dw - stw - idw - lw;
  endfunction

  function automatic int addr_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/axi_ax_cmd_fifo.sv
// Synchronous command FIFO; full/empty are derived from the occupancy count.
module axi_ax_cmd_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_occupancy = r_count;

endmodule

// File: rtl/stream_to_axi_ax.sv
// Decodes snooped Ax records from an AXI-Stream link, filters by record type,
// buffers matching commands and replays them on an AXI4 address channel.
module stream_to_axi_ax
  import stream_record_pkg::*;
#(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ADDR_WIDTH        = 64,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           BURST_LEN         = 8,
  parameter int                           LOCK_WIDTH        = 2,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b0,
  parameter int                           FIFO_DEPTH        = 4,
  parameter logic [2:0]                   DEF_SIZE          = 3'd4,
  parameter logic [1:0]                   DEF_BURST         = 2'b01,
  parameter logic [3:0]                   DEF_CACHE         = 4'b0011,
  parameter logic [2:0]                   DEF_PROT          = 3'b000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic [ID_WIDTH-1:0]           AXIM_axid,
  output logic [ADDR_WIDTH-1:0]         AXIM_axaddr,
  output logic [BURST_LEN-1:0]          AXIM_axlen,
  output logic [2:0]                    AXIM_axsize,
  output logic [1:0]                    AXIM_axburst,
  output logic [LOCK_WIDTH-1:0]         AXIM_axlock,
  output logic [3:0]                    AXIM_axcache,
  output logic [2:0]                    AXIM_axprot,
  output logic [3:0]                    AXIM_axregion,
  output logic [3:0]                    AXIM_axqos,
  output logic [USER_WIDTH-1:0]         AXIM_axuser,
  output logic                          AXIM_axvalid,
  input  logic                          AXIM_axready,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   err_count,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int TYPE_LSB = type_lsb(DATA_WIDTH, STREAM_TYPE_WIDTH);
  localparam int ID_LSB   = id_lsb(DATA_WIDTH, STREAM_TYPE_WIDTH, ID_WIDTH);
  localparam int LEN_LSB  = len_lsb(DATA_WIDTH, STREAM_TYPE_WIDTH, ID_WIDTH, BURST_LEN);
  localparam int CMD_W    = ID_WIDTH + BURST_LEN + ADDR_WIDTH;

  if (STREAM_TYPE_WIDTH + ID_WIDTH + BURST_LEN + ADDR_WIDTH > DATA_WIDTH) begin : g_bad_layout
    $error("stream_to_axi_ax: record fields do not fit in DATA_WIDTH");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [STREAM_TYPE_WIDTH-1:0] w_type;
  logic [ID_WIDTH-1:0]          w_id;
  logic [BURST_LEN-1:0]         w_len;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic                         w_unused_tdata;
  logic                         w_accept;
  logic                         w_match;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic [CMD_W-1:0]             w_head;
  logic [15:0]                  r_drop_count;
  logic [15:0]                  r_err_count;

  assign w_type         = s_tdata[TYPE_LSB +: STREAM_TYPE_WIDTH];
  assign w_id           = s_tdata[ID_LSB +: ID_WIDTH];
  assign w_len          = s_tdata[LEN_LSB +: BURST_LEN];
  assign w_addr         = s_tdata[ADDR_WIDTH-1:0];
  assign w_unused_tdata = ^s_tdata;

  // Tready is forced low while reset is held so no beat is taken during reset.
  assign s_tready = resetn & ~w_full;
  assign w_accept = s_tvalid & s_tready;
  assign w_match  = (w_type == STREAM_TYPE);
  assign w_push   = w_accept & w_match & s_tlast;
  assign w_pop    = AXIM_axvalid & AXIM_axready;

  axi_ax_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (resetn),
    .i_push      (w_push),
    .i_data      ({w_id, w_len, w_addr}),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_count <= '0;
      r_err_count  <= '0;
    end else if (w_accept) begin
      if (!w_match)      r_drop_count <= sat_inc(r_drop_count);
      else if (!s_tlast) r_err_count  <= sat_inc(r_err_count);
    end
  end

  assign drop_count = r_drop_count;
  assign err_count  = r_err_count;

  // Head fields are masked while empty so stale storage never reaches the port.
  assign AXIM_axvalid  = ~w_empty;
  assign AXIM_axid     = w_empty ? '0 : w_head[CMD_W-1 -: ID_WIDTH];
  assign AXIM_axlen    = w_empty ? '0 : w_head[ADDR_WIDTH +: BURST_LEN];
  assign AXIM_axaddr   = w_empty ? '0 : w_head[ADDR_WIDTH-1:0];
  assign AXIM_axsize   = DEF_SIZE;
  assign AXIM_axburst  = DEF_BURST;
  assign AXIM_axlock   = '0;
  assign AXIM_axcache  = DEF_CACHE;
  assign AXIM_axprot   = DEF_PROT;
  assign AXIM_axregion = '0;
  assign AXIM_axqos    = '0;
  assign AXIM_axuser   = '0;

endmodule

// File: tb/tb_stream_to_axi_ax.sv
// Directed bench for stream_to_axi_ax with hand-computed expectations.
module tb_stream_to_axi_ax;

  logic          clk = 1'b0;
  logic          resetn;
  logic [127:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [31:0]   AXIM_axid;
  logic [63:0]   AXIM_axaddr;
  logic [7:0]    AXIM_axlen;
  logic [2:0]    AXIM_axsize;
  logic [1:0]    AXIM_axburst;
  logic [1:0]    AXIM_axlock;
  logic [3:0]    AXIM_axcache;
  logic [2:0]    AXIM_axprot;
  logic [3:0]    AXIM_axregion;
  logic [3:0]    AXIM_axqos;
  logic [63:0]   AXIM_axuser;
  logic          AXIM_axvalid;
  logic          AXIM_axready;
  logic [15:0]   drop_count;
  logic [15:0]   err_count;
  logic [2:0]    occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  stream_to_axi_ax dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .AXIM_axid     (AXIM_axid),
    .AXIM_axaddr   (AXIM_axaddr),
    .AXIM_axlen    (AXIM_axlen),
    .AXIM_axsize   (AXIM_axsize),
    .AXIM_axburst  (AXIM_axburst),
    .AXIM_axlock   (AXIM_axlock),
    .AXIM_axcache  (AXIM_axcache),
    .AXIM_axprot   (AXIM_axprot),
    .AXIM_axregion (AXIM_axregion),
    .AXIM_axqos    (AXIM_axqos),
    .AXIM_axuser   (AXIM_axuser),
    .AXIM_axvalid  (AXIM_axvalid),
    .AXIM_axready  (AXIM_axready),
    .drop_count    (drop_count),
    .err_count     (err_count),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] t, input logic [31:0] id, input logic [7:0] len,
                      input logic [63:0] addr, input logic last);
    s_tdata  = {t, id, len, 21'd0, addr};
    s_tlast  = last;
    s_tvalid = 1'b1;
  endtask

  initial begin
    resetn       = 1'b0;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    AXIM_axready = 1'b0;
    #2;
    chk("rst_tready",   64'(s_tready), 64'd0);
    chk("rst_axvalid",  64'(AXIM_axvalid), 64'd0);
    chk("rst_occ",      64'(occupancy), 64'd0);
    chk("rst_drop",     64'(drop_count), 64'd0);
    chk("rst_err",      64'(err_count), 64'd0);
    chk("rst_axid",     64'(AXIM_axid), 64'd0);
    chk("rst_axaddr",   AXIM_axaddr, 64'd0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rel_tready",   64'(s_tready), 64'd1);

    // single record
    tick();
    beat(3'd0, 32'h5, 8'h7, 64'h1000, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("s1_axvalid",   64'(AXIM_axvalid), 64'd1);
    chk("s1_axid",      64'(AXIM_axid), 64'h5);
    chk("s1_axlen",     64'(AXIM_axlen), 64'h7);
    chk("s1_axaddr",    AXIM_axaddr, 64'h1000);
    chk("s1_axsize",    64'(AXIM_axsize), 64'd4);
    chk("s1_axburst",   64'(AXIM_axburst), 64'd1);
    chk("s1_occ",       64'(occupancy), 64'd1);
    tick();
    chk("s1_hold_vld",  64'(AXIM_axvalid), 64'd1);
    chk("s1_hold_id",   64'(AXIM_axid), 64'h5);
    AXIM_axready = 1'b1;
    tick();
    AXIM_axready = 1'b0;
    chk("s1_pop_vld",   64'(AXIM_axvalid), 64'd0);
    chk("s1_pop_occ",   64'(occupancy), 64'd0);

    // backpressure: four fill the FIFO, the fifth is stalled
    for (int i = 0; i < 4; i++) begin
      beat(3'd0, 32'h10 + 32'(i), 8'(i), 64'h2000 + 64'(i), 1'b1);
      chk("bp_tready_on", 64'(s_tready), 64'd1);
      tick();
    end
    beat(3'd0, 32'h14, 8'h4, 64'h2004, 1'b1);
    chk("bp_occ_full",  64'(occupancy), 64'd4);
    chk("bp_tready_off", 64'(s_tready), 64'd0);
    tick();
    chk("bp_still_off", 64'(s_tready), 64'd0);
    chk("bp_head0",     64'(AXIM_axid), 64'h10);
    AXIM_axready = 1'b1;
    tick();
    chk("bp_pop1_occ",  64'(occupancy), 64'd3);
    chk("bp_pop1_id",   64'(AXIM_axid), 64'h11);
    chk("bp_reready",   64'(s_tready), 64'd1);
    tick();
    s_tvalid = 1'b0;
    chk("bp_push5_occ", 64'(occupancy), 64'd3);
    chk("bp_id12",      64'(AXIM_axid), 64'h12);
    chk("bp_addr12",    AXIM_axaddr, 64'h2002);
    tick();
    chk("bp_id13",      64'(AXIM_axid), 64'h13);
    tick();
    chk("bp_id14",      64'(AXIM_axid), 64'h14);
    chk("bp_addr14",    AXIM_axaddr, 64'h2004);
    tick();
    chk("bp_drained",   64'(AXIM_axvalid), 64'd0);
    AXIM_axready = 1'b0;

    // filtering
    beat(3'd1, 32'h99, 8'h1, 64'h3000, 1'b1);
    chk("flt_tready",   64'(s_tready), 64'd1);
    tick();
    chk("flt_drop",     64'(drop_count), 64'd1);
    chk("flt_novld",    64'(AXIM_axvalid), 64'd0);
    beat(3'd0, 32'h98, 8'h1, 64'h3004, 1'b0);
    tick();
    s_tvalid = 1'b0;
    chk("flt_err",      64'(err_count), 64'd1);
    chk("flt_drop2",    64'(drop_count), 64'd1);
    chk("flt_novld2",   64'(AXIM_axvalid), 64'd0);
    chk("flt_occ",      64'(occupancy), 64'd0);

    // simultaneous push/pop across pointer wrap
    for (int i = 0; i < 2; i++) begin
      beat(3'd0, 32'h20 + 32'(i), 8'h0, 64'h4000 + 64'(i), 1'b1);
      tick();
    end
    chk("pp_occ_start", 64'(occupancy), 64'd2);
    AXIM_axready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      beat(3'd0, 32'h22 + 32'(k), 8'h0, 64'h4002 + 64'(k), 1'b1);
      tick();
      chk("pp_occ",     64'(occupancy), 64'd2);
      chk("pp_head",    64'(AXIM_axid), 64'h21 + 64'(k));
    end
    s_tvalid = 1'b0;
    tick();
    chk("pp_tail",      64'(AXIM_axid), 64'h29);
    tick();
    chk("pp_empty",     64'(AXIM_axvalid), 64'd0);
    AXIM_axready = 1'b0;

    // reset with commands buffered
    for (int i = 0; i < 3; i++) begin
      beat(3'd0, 32'h30 + 32'(i), 8'h0, 64'h5000, 1'b1);
      tick();
    end
    s_tvalid = 1'b0;
    chk("rm_occ3",      64'(occupancy), 64'd3);
    resetn = 1'b0;
    #1;
    chk("rm_axvalid",   64'(AXIM_axvalid), 64'd0);
    chk("rm_occ",       64'(occupancy), 64'd0);
    chk("rm_axid",      64'(AXIM_axid), 64'd0);
    chk("rm_drop",      64'(drop_count), 64'd0);
    chk("rm_err",       64'(err_count), 64'd0);
    chk("rm_tready",    64'(s_tready), 64'd0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rm_rel_tready", 64'(s_tready), 64'd1);
    chk("rm_rel_occ",   64'(occupancy), 64'd0);
    AXIM_axready = 1'b1;
    tick();
    chk("rm_no_stale",  64'(AXIM_axvalid), 64'd0);
    AXIM_axready = 1'b0;

    // drop counter saturation
    beat(3'd2, 32'h0, 8'h0, 64'h0, 1'b1);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe",     64'(drop_count), 64'hFFFE);
    for (int i = 0; i < 6; i++) tick();
    s_tvalid = 1'b0;
    chk("sat_ffff",     64'(drop_count), 64'hFFFF);
    chk("sat_err",      64'(err_count), 64'd0);
    chk("sat_novld",    64'(AXIM_axvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
